md_sequencer: RTL and testbench

// - Multi-cycle multiply/divide controller for the EX stage; owns the HI/LO registers.
// - Accepts MD ops from EX (decoded MDFunc/MDSign): MULT, DIV, MTHI, MTLO.
// - Sequences an iterative multiplier and a radix-2 restoring divider.
// - Raises a stall so the hazard logic freezes IF/ID/EX while a result is pending.

---
 rtl/md_if.sv | 27 ++
 rtl/md_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_md_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// Handshake/result bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The master side is the EX stage. The slave side is md_sequencer.
interface md_if #(
   parameter int DW = 32
);
   logic          start;
   logic [2:0]    md_func;
   logic          md_sign;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          md_read;
   logic          busy;
   logic          stall;
   logic          done;
   logic [DW-1:0] hi;
   logic [DW-1:0] lo;

   modport master (
      output start, md_func, md_sign, op_a, op_b, md_read,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  start, md_func, md_sign, op_a, op_b, md_read,
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO, with a radix-2 restoring divider.
// Optional feature macro MD_FAST_MULT_EN selects a single-cycle registered multiplier.
module md_sequencer #(
   parameter int DW      = 32,
   parameter int MUL_LAT = 4
) (
   input logic clk,
   input logic rst_n,
   md_if.slave md
);
   localparam int CMAX = (DW > MUL_LAT) ? DW : MUL_LAT;
   localparam int CW   = $clog2(CMAX) + 1;

   localparam logic [2:0] F_MULT = 3'b001;
   localparam logic [2:0] F_DIV  = 3'b010;
   localparam logic [2:0] F_MTHI = 3'b011;
   localparam logic [2:0] F_MTLO = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic          sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
   logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
   logic          done_q, done_d, busy_q, busy_d;
   logic [2*DW-1:0] prod_s;
   logic [DW:0]     rem_sh_s, diff_s;
   logic            accept_s;
`ifdef MD_FAST_MULT_EN
   logic [2*DW-1:0] prod_q, prod_d;
`else
   logic [DW-1:0]   b_q, b_d;
   logic            sign_q, sign_d;
`endif

   function automatic logic [2*DW-1:0] mul_full(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic sgn);
      logic [2*DW-1:0] ea;
      logic [2*DW-1:0] eb;
      ea = {{DW{sgn & a[DW-1]}}, a};
      eb = {{DW{sgn & b[DW-1]}}, b};
      return ea * eb;
   endfunction

   function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] x, input logic neg);
      return neg ? ((~x) + {{(DW-1){1'b0}}, 1'b1}) : x;
   endfunction

   assign accept_s = md.start & ~busy_q;

`ifdef MD_FAST_MULT_EN
   assign prod_s = prod_q;
`else
   assign prod_s = mul_full(a_q, b_q, sign_q);
`endif

   // One restoring step: shift in the next dividend bit and subtract when it fits.
   assign rem_sh_s = {rem_q, quo_q[DW-1]};
   assign diff_s   = rem_sh_s - {1'b0, dvs_q};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && md.md_func == F_MULT) begin
               state_d = ST_MUL;
            end else if (accept_s && md.md_func == F_DIV) begin
               state_d = ST_DIV;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DIV: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_DIV;
            end
         end
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: operand capture, iteration, HI/LO writeback
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      sq_d   = sq_q;
      sr_d   = sr_q;
      dz_d   = dz_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      busy_d = (state_d != ST_IDLE);
`ifdef MD_FAST_MULT_EN
      prod_d = prod_q;
`else
      b_d    = b_q;
      sign_d = sign_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (md.md_func)
                  F_MULT: begin
                     a_d = md.op_a;
`ifdef MD_FAST_MULT_EN
                     prod_d = mul_full(md.op_a, md.op_b, md.md_sign);
                     cnt_d  = {CW{1'b0}};
`else
                     b_d    = md.op_b;
                     sign_d = md.md_sign;
                     cnt_d  = CW'(MUL_LAT - 1);
`endif
                  end
                  F_DIV: begin
                     a_d   = md.op_a;
                     quo_d = neg_if(md.op_a, md.md_sign & md.op_a[DW-1]);
                     dvs_d = neg_if(md.op_b, md.md_sign & md.op_b[DW-1]);
                     rem_d = {DW{1'b0}};
                     sq_d  = md.md_sign & (md.op_a[DW-1] ^ md.op_b[DW-1]);
                     sr_d  = md.md_sign & md.op_a[DW-1];
                     dz_d  = (md.op_b == {DW{1'b0}});
                     cnt_d = CW'(DW - 1);
                  end
                  F_MTHI:  hi_d = md.op_a;
                  F_MTLO:  lo_d = md.op_a;
                  default: hi_d = hi_q;
               endcase
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_MUL: begin
            if (cnt_q == {CW{1'b0}}) begin
               {hi_d, lo_d} = prod_s;
               done_d       = 1'b1;
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_DIV: begin
            if (!diff_s[DW]) begin
               rem_d = diff_s[DW-1:0];
               quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
               rem_d = rem_sh_s[DW-1:0];
               quo_d = {quo_q[DW-2:0], 1'b0};
            end
            if (cnt_q != {CW{1'b0}}) begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_FIX: begin
            done_d = 1'b1;
            // A zero divisor returns the raw dividend in HI, whatever the signedness.
            if (dz_q) begin
               hi_d = a_q;
               lo_d = {DW{1'b1}};
            end else begin
               hi_d = neg_if(rem_q, sr_q);
               lo_d = neg_if(quo_q, sq_q);
            end
         end
         default: done_d = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= {CW{1'b0}};
         a_q    <= {DW{1'b0}};
         rem_q  <= {DW{1'b0}};
         quo_q  <= {DW{1'b0}};
         dvs_q  <= {DW{1'b0}};
         sq_q   <= 1'b0;
         sr_q   <= 1'b0;
         dz_q   <= 1'b0;
         hi_q   <= {DW{1'b0}};
         lo_q   <= {DW{1'b0}};
         done_q <= 1'b0;
         busy_q <= 1'b0;
`ifdef MD_FAST_MULT_EN
         prod_q <= {(2*DW){1'b0}};
`else
         b_q    <= {DW{1'b0}};
         sign_q <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         sq_q   <= sq_d;
         sr_q   <= sr_d;
         dz_q   <= dz_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
         busy_q <= busy_d;
`ifdef MD_FAST_MULT_EN
         prod_q <= prod_d;
`else
         b_q    <= b_d;
         sign_q <= sign_d;
`endif
      end
   end

   // Outputs; stall is the only combinational one so EX freezes in the same cycle
   always_comb begin
      md.busy  = busy_q;
      md.stall = busy_q & (md.start | md.md_read);
      md.done  = done_q;
      md.hi    = hi_q;
      md.lo    = lo_q;
   end
endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: MULT/DIV results, latency, stall, MTHI/MTLO, reset.
module tb_md_sequencer;
`ifdef MD_FAST_MULT_EN
   localparam int MUL_CYC = 1;
`else
   localparam int MUL_CYC = 4;
`endif
   localparam int DIV_CYC = 33;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   int   cyc;
   int   stl;

   md_if #(.DW(32)) mdi ();

   md_sequencer #(.DW(32), .MUL_LAT(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .md   (mdi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge, drop start after the accept edge, count busy/stall cycles.
   task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic rd, output int n_busy,
                         output int n_stall);
      @(negedge clk);
      mdi.start   = 1'b1;
      mdi.md_func = f;
      mdi.md_sign = s;
      mdi.op_a    = a;
      mdi.op_b    = b;
      mdi.md_read = rd;
      @(negedge clk);
      mdi.start = 1'b0;
      #1;
      n_busy  = 0;
      n_stall = 0;
      while (mdi.busy === 1'b1 && n_busy < 200) begin
         n_busy++;
         if (mdi.stall === 1'b1) n_stall++;
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      n_chk       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      mdi.start   = 1'b0;
      mdi.md_func = 3'b000;
      mdi.md_sign = 1'b0;
      mdi.op_a    = 32'h0;
      mdi.op_b    = 32'h0;
      mdi.md_read = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'd0, mdi.busy}, 64'd0);
      chk("rst_done", {63'd0, mdi.done}, 64'd0);
      chk("rst_hilo", {mdi.hi, mdi.lo}, 64'd0);
      rst_n = 1'b1;

      // Signed MULT -3 * 7
      run_op(3'b001, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc, stl);
      chk("mul_cyc", 64'(cyc), 64'(MUL_CYC));
      chk("mul_done", {63'd0, mdi.done}, 64'd1);
      chk("mul_hilo", {mdi.hi, mdi.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      @(negedge clk);
      chk("done_pulse", {63'd0, mdi.done}, 64'd0);

      // Unsigned MULTU of the same bit pattern
      run_op(3'b001, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc, stl);
      chk("mulu_hilo", {mdi.hi, mdi.lo}, 64'h0000_0006_FFFF_FFEB);

      // DIVU 100 / 7 with md_read held to check the stall
      run_op(3'b010, 1'b0, 32'd100, 32'd7, 1'b1, cyc, stl);
      chk("divu_cyc", 64'(cyc), 64'(DIV_CYC));
      chk("divu_stall", 64'(stl), 64'(DIV_CYC));
      chk("divu_nostall", {63'd0, mdi.stall}, 64'd0);
      chk("divu_done", {63'd0, mdi.done}, 64'd1);
      chk("divu_hilo", {mdi.hi, mdi.lo}, {32'd2, 32'd14});
      mdi.md_read = 1'b0;

      run_op(3'b010, 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, cyc, stl);
      chk("divu_big", {mdi.hi, mdi.lo}, {32'hF, 32'h0FFF_FFFF});

      run_op(3'b010, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, stl);
      chk("div_neg", {mdi.hi, mdi.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      run_op(3'b010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, stl);
      chk("div_ovf_cyc", 64'(cyc), 64'(DIV_CYC));
      chk("div_ovf", {mdi.hi, mdi.lo}, {32'h0, 32'h8000_0000});

      run_op(3'b010, 1'b0, 32'h1234, 32'h0, 1'b0, cyc, stl);
      chk("div0_cyc", 64'(cyc), 64'(DIV_CYC));
      chk("div0_done", {63'd0, mdi.done}, 64'd1);
      chk("div0_hilo", {mdi.hi, mdi.lo}, {32'h1234, 32'hFFFF_FFFF});

      run_op(3'b010, 1'b1, 32'hFFFF_FFFB, 32'h0, 1'b0, cyc, stl);
      chk("div0s_hilo", {mdi.hi, mdi.lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

      // MTHI while idle, then md_read right after needs no stall
      @(negedge clk);
      mdi.start   = 1'b1;
      mdi.md_func = 3'b011;
      mdi.op_a    = 32'hA5A5_0000;
      #1;
      chk("mthi_nostall", {63'd0, mdi.stall}, 64'd0);
      @(negedge clk);
      mdi.start   = 1'b0;
      mdi.md_read = 1'b1;
      #1;
      chk("mthi_hi", {32'd0, mdi.hi}, {32'd0, 32'hA5A5_0000});
      chk("mthi_lo", {32'd0, mdi.lo}, {32'd0, 32'hFFFF_FFFF});
      chk("mfhi_nostall", {63'd0, mdi.stall}, 64'd0);
      chk("mthi_busy", {63'd0, mdi.busy}, 64'd0);
      mdi.md_read = 1'b0;

      // NOP-coded func must not start anything
      @(negedge clk);
      mdi.start   = 1'b1;
      mdi.md_func = 3'b101;
      @(negedge clk);
      mdi.start = 1'b0;
      #1;
      chk("nop_busy", {63'd0, mdi.busy}, 64'd0);

      // MTLO held in EX while a DIVU is running
      @(negedge clk);
      mdi.start   = 1'b1;
      mdi.md_func = 3'b010;
      mdi.md_sign = 1'b0;
      mdi.op_a    = 32'd100;
      mdi.op_b    = 32'd7;
      @(negedge clk);
      mdi.md_func = 3'b100;
      mdi.op_a    = 32'h5555_AAAA;
      #1;
      chk("mtlo_stall", {63'd0, mdi.stall}, 64'd1);
      cyc = 0;
      while (mdi.busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
         #1;
      end
      chk("mtlo_wait", 64'(cyc), 64'(DIV_CYC));
      chk("mtlo_prelo", {32'd0, mdi.lo}, 64'd14);
      @(negedge clk);
      mdi.start = 1'b0;
      #1;
      chk("mtlo_hilo", {mdi.hi, mdi.lo}, {32'd2, 32'h5555_AAAA});

      // Reset in the middle of a DIV aborts it
      @(negedge clk);
      mdi.start   = 1'b1;
      mdi.md_func = 3'b010;
      mdi.md_sign = 1'b1;
      mdi.op_a    = 32'hFFFF_FFF9;
      mdi.op_b    = 32'd2;
      @(negedge clk);
      mdi.start = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      chk("pre_rst_busy", {63'd0, mdi.busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, mdi.busy}, 64'd0);
      chk("mid_rst_hilo", {mdi.hi, mdi.lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'b001, 1'b1, 32'd5, 32'd6, 1'b0, cyc, stl);
      chk("post_rst_cyc", 64'(cyc), 64'(MUL_CYC));
      chk("post_rst_mul", {mdi.hi, mdi.lo}, {32'd0, 32'd30});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
